// File: rtl/decode_in_queue_if.sv
// decode_in_queue_if: fetch-side handshake plus decode_in bus of the staging FIFO
interface decode_in_queue_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16,
  parameter int PSR_W   = 3,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_npc;
  logic [PSR_W-1:0]   in_psr;
  logic               stall;
  logic               flush;
  logic               enable_decode;
  logic [INSTR_W-1:0] Instr_dout;
  logic [PC_W-1:0]    npc_in;
  logic [PSR_W-1:0]   psr;
  logic [CW-1:0]      count;
  logic [CNT_W-1:0]   flush_count;
  modport master (
    output in_valid, in_instr, in_npc, in_psr, stall, flush,
    input  in_ready, enable_decode, Instr_dout, npc_in, psr, count, flush_count
  );
  modport slave (
    input  in_valid, in_instr, in_npc, in_psr, stall, flush,
    output in_ready, enable_decode, Instr_dout, npc_in, psr, count, flush_count
  );
endinterface

// File: rtl/decode_in_queue.sv
// decode_in_queue: fall-through fetch-to-decode FIFO with stall, flush and flush statistics
module decode_in_queue #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16,
  parameter int PSR_W   = 3,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input logic              clock,
  input logic              reset,
  decode_in_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = INSTR_W + PC_W + PSR_W;
  logic [BW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] fc_q, fc_d;
  logic             push, pop;
  logic [BW-1:0]    head;
  always_comb begin
    push    = q.in_valid & q.in_ready & ~q.flush;
    pop     = (count_q != '0) & ~q.stall & ~q.flush;
    rd_d    = q.flush ? wr_q : rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push);
    count_d = q.flush ? '0 : count_q + CW'(push) - CW'(pop);
    fc_d    = (q.flush && count_q != '0 && fc_q != '1) ? fc_q + CNT_W'(1) : fc_q;
    head    = (count_q != '0) ? mem_q[rd_q] : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      fc_q    <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      fc_q    <= fc_d;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wr_q] <= {q.in_instr, q.in_npc, q.in_psr};
  end
  assign q.in_ready      = count_q < CW'(DEPTH);
  assign q.enable_decode = count_q != '0;
  assign {q.Instr_dout, q.npc_in, q.psr} = head;
  assign q.count         = count_q;
  assign q.flush_count   = fc_q;
endmodule

// File: tb/tb_decode_in_queue.sv
// tb_decode_in_queue: random and directed stimulus against a queue-based reference model
module tb_decode_in_queue;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;
  logic [34:0] mq[$];
  int fc8 = 0;
  int fc2 = 0;
  always #5 clock = ~clock;
  decode_in_queue_if #(.CNT_W(8)) a ();
  decode_in_queue_if #(.CNT_W(2)) b ();
  assign b.in_valid = a.in_valid;
  assign b.in_instr = a.in_instr;
  assign b.in_npc   = a.in_npc;
  assign b.in_psr   = a.in_psr;
  assign b.stall    = a.stall;
  assign b.flush    = a.flush;
  decode_in_queue #(.CNT_W(8)) dut  (.clock(clock), .reset(reset), .q(a));
  decode_in_queue #(.CNT_W(2)) dut2 (.clock(clock), .reset(reset), .q(b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic f);
    a.in_valid = v;
    a.stall    = s;
    a.flush    = f;
    a.in_instr = 16'($urandom);
    a.in_npc   = 16'($urandom);
    a.in_psr   = 3'($urandom);
  endtask

  task automatic step();
    logic [34:0] bundle;
    logic pu, po;
    bundle = {a.in_instr, a.in_npc, a.in_psr};
    @(posedge clock);
    if (reset) begin
      mq.delete();
      fc8 = 0;
      fc2 = 0;
    end else if (a.flush) begin
      if (mq.size() != 0) begin
        fc8 = (fc8 < 255) ? fc8 + 1 : 255;
        fc2 = (fc2 < 3) ? fc2 + 1 : 3;
      end
      mq.delete();
    end else begin
      pu = a.in_valid && mq.size() < DEPTH;
      po = mq.size() != 0 && !a.stall;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(bundle);
    end
    @(negedge clock);
    chk("enable_decode", 64'(a.enable_decode), 64'(mq.size() != 0));
    chk("in_ready", 64'(a.in_ready), 64'(mq.size() < DEPTH));
    chk("count", 64'(a.count), 64'(mq.size()));
    chk("head", 64'({a.Instr_dout, a.npc_in, a.psr}), 64'(mq.size() != 0 ? mq[0] : 35'd0));
    chk("flush_count", 64'(a.flush_count), 64'(fc8));
    chk("flush_count_sat2", 64'(b.flush_count), 64'(fc2));
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    step();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    a.in_instr = 16'h3021;
    a.in_npc   = 16'h3001;
    a.in_psr   = 3'b010;
    step();
    chk("t1_instr", 64'(a.Instr_dout), 64'h3021);
    chk("t1_npc", 64'(a.npc_in), 64'h3001);
    chk("t1_psr", 64'(a.psr), 64'h2);
    drive(1'b0, 1'b0, 1'b0);
    step();
    chk("t1_empty", 64'({a.enable_decode, a.Instr_dout}), 64'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      step();
    end
    chk("t2_full", 64'({a.in_ready, a.count}), 64'h4);
    a.stall = 1'b0;
    step();
    step();
    a.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      step();
      chk("t3_count", 64'(a.count), 64'd2);
    end
    drive(1'b0, 1'b1, 1'b0);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 1'b1);
    step();
    chk("t4_flush_count", 64'(a.flush_count), 64'd1);
    step();
    chk("t4_flush_empty", 64'(a.flush_count), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      step();
    end
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    chk("t5_reset", 64'({a.enable_decode, a.in_ready, a.count, a.flush_count}), 64'h800);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      step();
      drive(1'b0, 1'b0, 1'b1);
      step();
      chk("t6_sat", 64'(b.flush_count), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(99) == 0);
      drive(1'($urandom_range(9) < 7), 1'($urandom_range(9) < 4), 1'($urandom_range(19) == 0));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
